// File: rtl/uart_tx_feeder_if.sv
// Core-side byte stream and transmitter-side strobe for the UART TX feeder.
// The master (core/bench) pushes bytes and reads status; the slave is the feeder.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_overflow;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              uart_wr_o;
  logic [7:0]        uart_dat_o;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  full, empty, count, overflow, uart_wr_o, uart_dat_o
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output full, empty, count, overflow, uart_wr_o, uart_dat_o
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// UART TX feeder: buffers MMIO byte stores in a circular FIFO and paces them
// to the transmitter as one-cycle strobes, at most one per frame time, since
// the transmitter has no busy flag of its own.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int FRAME_CYCLES = 9600
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     HOLD_RELOAD = 16'(FRAME_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              uart_wr_q;
  logic [7:0]        uart_dat_q;
  logic [15:0]       hold_cnt;
  state_t            state;
  logic              push_ok;
  logic              push_drop;
  logic              pop_ok;

  // Decide push/pop for this edge; a full FIFO drops the push even if a pop frees a slot.
  always_comb begin
    push_ok    = bus.wr_en && !full_q;
    push_drop  = bus.wr_en && full_q;
    pop_ok     = (count_q != '0) && ((state == IDLE) || (hold_cnt == 16'd0));
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_q - 1'b1;
    end
  end

  // Storage array; no reset needed because count guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, status flags, and the IDLE/HOLD pacing FSM with registered strobe/data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
      hold_cnt   <= 16'd0;
      state      <= IDLE;
    end else begin
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);

      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (push_drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end

      uart_wr_q <= 1'b0;
      if (pop_ok) begin
        uart_dat_q <= mem[rd_ptr];
        uart_wr_q  <= 1'b1;
        rd_ptr     <= rd_ptr + 1'b1;
        hold_cnt   <= HOLD_RELOAD;
        state      <= HOLD;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          HOLD: begin
            if (hold_cnt != 16'd0) begin
              hold_cnt <= hold_cnt - 16'd1;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.uart_wr_o  = uart_wr_q;
  assign bus.uart_dat_o = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with FRAME_CYCLES = 20 and DEPTH = 16.
module tb_uart_tx_feeder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  uart_tx_feeder_if #(.ADDR_W(4)) bus ();

  uart_tx_feeder #(
    .DEPTH(16),
    .ADDR_W(4),
    .FRAME_CYCLES(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int limit, output bit seen, output int cycles,
                             output logic [7:0] data);
    seen   = 1'b0;
    cycles = 0;
    data   = 8'h00;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      cycles++;
      if (bus.uart_wr_o === 1'b1) begin
        seen = 1'b1;
        data = bus.uart_dat_o;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_overflow = 1'b0;
    #2;
    reset = 1'b0;
    repeat (2) tick();
    total++; if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b exp=0", bus.overflow); end
    total++; if (bus.uart_wr_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr got=%b exp=0", bus.uart_wr_o); end
    total++; if (bus.uart_dat_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_dat got=%h exp=00", bus.uart_dat_o); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.wr_en = 1'b1; bus.wr_data = 8'h41;
    tick();
    bus.wr_en = 1'b0;
    total++; if (bus.count !== 5'd1) begin bad++; $display("[TB] FAIL single_count_after_push got=%0d exp=1", bus.count); end
    total++; if (bus.uart_wr_o !== 1'b0) begin bad++; $display("[TB] FAIL single_no_bypass got=%b exp=0", bus.uart_wr_o); end
    tick();
    total++; if (bus.uart_wr_o !== 1'b1) begin bad++; $display("[TB] FAIL single_strobe got=%b exp=1", bus.uart_wr_o); end
    total++; if (bus.uart_dat_o !== 8'h41) begin bad++; $display("[TB] FAIL single_data got=%h exp=41", bus.uart_dat_o); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("[TB] FAIL single_count_after_pop got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL single_empty got=%b exp=1", bus.empty); end
    tick();
    total++; if (bus.uart_wr_o !== 1'b0) begin bad++; $display("[TB] FAIL single_strobe_width got=%b exp=0", bus.uart_wr_o); end
    total++; if (bus.uart_dat_o !== 8'h41) begin bad++; $display("[TB] FAIL single_data_held got=%h exp=41", bus.uart_dat_o); end
    repeat (25) tick();
  endtask

  task automatic test_burst();
    bit          seen;
    int          cyc;
    logic [7:0]  d;
    int          extra;
    bus.wr_en = 1'b1; bus.wr_data = 8'h10;
    tick();
    bus.wr_data = 8'h11;
    tick();
    total++; if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'h10) begin bad++; $display("[TB] FAIL burst_first wr=%b dat=%h exp wr=1 dat=10", bus.uart_wr_o, bus.uart_dat_o); end
    bus.wr_data = 8'h12;
    tick();
    bus.wr_en = 1'b0;
    wait_strobe(60, seen, cyc, d);
    total++; if (!seen || cyc != 19 || d !== 8'h11) begin bad++; $display("[TB] FAIL burst_second seen=%0d cycles=%0d dat=%h exp 1/19/11", seen, cyc, d); end
    wait_strobe(60, seen, cyc, d);
    total++; if (!seen || cyc != 20 || d !== 8'h12) begin bad++; $display("[TB] FAIL burst_third seen=%0d cycles=%0d dat=%h exp 1/20/12", seen, cyc, d); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.uart_wr_o === 1'b1) extra++;
    end
    total++; if (extra != 0 || bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL burst_quiet extra=%0d empty=%b exp 0/1", extra, bus.empty); end
    bus.wr_en = 1'b1; bus.wr_data = 8'hC3;
    tick();
    bus.wr_en = 1'b0;
    tick();
    total++; if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'hC3) begin bad++; $display("[TB] FAIL burst_idle_latency wr=%b dat=%h exp 1/c3", bus.uart_wr_o, bus.uart_dat_o); end
    repeat (25) tick();
  endtask

  task automatic test_overflow();
    bit          seen;
    int          cyc;
    logic [7:0]  d;
    bus.wr_en = 1'b1; bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    tick();
    total++; if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'hAA) begin bad++; $display("[TB] FAIL ovf_lead wr=%b dat=%h exp 1/aa", bus.uart_wr_o, bus.uart_dat_o); end
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    total++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin bad++; $display("[TB] FAIL ovf_full full=%b count=%0d exp 1/16", bus.full, bus.count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", bus.overflow); end
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b exp=0", bus.overflow); end
    tick();
    total++; if (bus.uart_wr_o !== 1'b0 || bus.count !== 5'd16) begin bad++; $display("[TB] FAIL ovf_still_holding wr=%b count=%0d exp 0/16", bus.uart_wr_o, bus.count); end
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    total++; if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'h00) begin bad++; $display("[TB] FAIL ovf_pop_edge wr=%b dat=%h exp 1/00", bus.uart_wr_o, bus.uart_dat_o); end
    total++; if (bus.count !== 5'd15 || bus.full !== 1'b0 || bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_push_while_full count=%0d full=%b ovf=%b exp 15/0/1", bus.count, bus.full, bus.overflow); end
    bus.wr_data = 8'h55;
    tick();
    total++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_refill count=%0d full=%b exp 16/1", bus.count, bus.full); end
    bus.wr_data = 8'h77; bus.clr_overflow = 1'b1;
    tick();
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
    bus.wr_en = 1'b0;
    tick();
    bus.clr_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear_again got=%b exp=0", bus.overflow); end
    for (int i = 1; i < 16; i++) begin
      wait_strobe(60, seen, cyc, d);
      total++; if (!seen || d !== 8'(i)) begin bad++; $display("[TB] FAIL ovf_drain_%0d seen=%0d dat=%h exp %h", i, seen, d, 8'(i)); end
    end
    wait_strobe(60, seen, cyc, d);
    total++; if (!seen || cyc != 20 || d !== 8'h55) begin bad++; $display("[TB] FAIL ovf_drain_last seen=%0d cycles=%0d dat=%h exp 1/20/55", seen, cyc, d); end
    wait_strobe(40, seen, cyc, d);
    total++; if (seen || bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL ovf_no_extra seen=%0d dat=%h empty=%b exp 0/-/1", seen, d, bus.empty); end
  endtask

  task automatic test_wrap();
    bit          seen;
    int          cyc;
    logic [7:0]  d;
    int          errs;
    errs = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bus.wr_en = 1'b1; bus.wr_data = 8'(i);
          tick();
          bus.wr_en = 1'b0;
          repeat (14) tick();
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          wait_strobe(100, seen, cyc, d);
          total++;
          if (!seen || d !== 8'(j)) begin
            bad++;
            $display("[TB] FAIL wrap_byte_%0d seen=%0d dat=%h exp %h", j, seen, d, 8'(j));
          end
        end
      end
    join
    total++; if (bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_end ovf=%b empty=%b exp 0/1", bus.overflow, bus.empty); end
    repeat (25) tick();
  endtask

  task automatic test_reset_mid_hold();
    int extra;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h81 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (3) tick();
    total++; if (bus.count !== 5'd5 || bus.uart_dat_o !== 8'h81) begin bad++; $display("[TB] FAIL rst_pre count=%0d dat=%h exp 5/81", bus.count, bus.uart_dat_o); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.uart_dat_o !== 8'h00 || bus.uart_wr_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_async count=%0d empty=%b dat=%h wr=%b exp 0/1/00/0", bus.count, bus.empty, bus.uart_dat_o, bus.uart_wr_o); end
    tick();
    reset = 1'b1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.uart_wr_o === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL rst_no_strobe got=%0d exp=0", extra); end
    bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    tick();
    bus.wr_en = 1'b0;
    tick();
    total++; if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'h99) begin bad++; $display("[TB] FAIL rst_new_byte wr=%b dat=%h exp 1/99", bus.uart_wr_o, bus.uart_dat_o); end
  endtask

  // Runs each scenario in order, then prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmitter: buffers bytes stored by the core (MMIO byte store) in a small FIFO and paces them out as single-cycle write strobes plus data.
- The transmitter exposes no busy flag, so this block enforces one full frame time between strobes with a hold-off counter.
- Status outputs (full/empty/count/overflow) go to the core's MMIO status register for polling.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- FRAME_CYCLES, 9600, clk cycles between consecutive strobes. 11 bit-times at 115200 baud from 100 MHz is about 9549, plus margin. Legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  push wr_data this cycle
- wr_data  input  8  byte to transmit
- clr_overflow  input  1  clear sticky overflow flag
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  ADDR_W+1  bytes currently buffered
- overflow  output  1  sticky: a push was dropped because FIFO was full
- uart_wr_o  output  1  one-cycle strobe to transmitter
- uart_dat_o  output  8  byte for transmitter; valid with strobe, held until next strobe

Behaviour:
- Reset (reset low, async): rd/wr pointers = 0, count = 0, overflow = 0, uart_wr_o = 0, uart_dat_o = 0, state = IDLE, hold counter = 0. Buffered bytes are discarded. Reset mid-hold aborts the frame timing; no strobe on the first edge after release unless data was pushed.
- FIFO: circular buffer. Pointers wrap modulo DEPTH. Push writes at wr_ptr; pop reads at rd_ptr. Strict byte order is preserved.
- full, empty and count are registered and reflect state after the last edge.
- Push rule: wr_en with full = 0 stores the byte. wr_en with full = 1 drops the byte and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): both happen and count is unchanged.
- No bypass: a byte pushed at edge N can be popped no earlier than edge N+1.
- overflow: set on a dropped push; cleared by clr_overflow. If set and clear occur in the same cycle, set wins.
- Pop/issue action (edge where pop occurs):
  - uart_dat_o <= mem[rd_ptr]
  - uart_wr_o <= 1
  - rd_ptr++ and count--
  - hold counter <= FRAME_CYCLES-1
  - state <= HOLD
- uart_wr_o is high for exactly one cycle per pop. It is 0 on every other edge.
- State machine (2 states):
  - IDLE: if count != 0, do the pop/issue action. Else stay in IDLE.
  - HOLD, hold counter != 0: decrement the counter.
  - HOLD, hold counter == 0: if count != 0, do the pop/issue action (back-to-back). Else go to IDLE.
- Timing: strobe spacing for back-to-back bytes is exactly FRAME_CYCLES cycles (strobe edges k and k+FRAME_CYCLES).
- Latency from IDLE with empty FIFO: wr_en sampled at edge N, strobe asserted after edge N+1.
- Hold counter width is 16 bits with no wrap. It never decrements below 0.

Test Plan:
- Single byte, IDLE, FRAME_CYCLES=20: push 0x41 at edge N -> count=1 after N; uart_wr_o=1 and uart_dat_o=0x41 for one cycle after N+1; count=0, empty=1; uart_dat_o stays 0x41.
- Burst, FRAME_CYCLES=20: push 0x10,0x11,0x12 on consecutive edges -> three strobes spaced exactly 20 cycles, data 0x10,0x11,0x12 in order; state IDLE 20 cycles after the last strobe.
- Overflow, DEPTH=16, long FRAME_CYCLES: push 0x00..0x10 (17 bytes) before the second pop -> full=1, byte 0x10 dropped (or the 17th past full), overflow=1 and sticky; clr_overflow -> overflow=0. Same-cycle set and clear -> overflow=1.
- Push while full during pop edge -> pushed byte dropped, overflow=1, count=DEPTH-1 after the edge.
- Wrap-around: stream 40 bytes 0x00..0x27 keeping the FIFO partly full -> strobed data exactly 0x00..0x27, no loss or duplication.
- Reset mid-HOLD with 5 bytes buffered: assert reset -> outputs immediately at reset values; after release, no strobe until a new push; the next strobe carries the new byte.
